// File: rtl/dot_matrix_pkg.sv
// Shared types for the dot-matrix display scheduler: FSM state encoding and slot counter widths.
package dot_matrix_pkg;

  localparam int DWELL_W = 16;
  localparam int BLANK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  typedef logic [DWELL_W-1:0] dwell_cnt_t;
  typedef logic [BLANK_W-1:0] blank_cnt_t;

endpackage

// File: rtl/dot_matrix_display_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, pointer advances only on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // ptr_q=0 favours requester 0, ptr_q=1 favours requester 1
  logic ptr_q;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept_i && (grant_o != 2'b00)) begin
      ptr_q <= grant_o[0];
    end
  end

endmodule

// File: rtl/dot_matrix_display_scheduler.sv
// Time-slices one dot-matrix display between two requesters: show a digit, blank, then rearbitrate.
module dot_matrix_display_scheduler
  import dot_matrix_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] code0,
  input  logic [2:0] code1,
  output logic [1:0] ack,
  output logic [2:0] ascii_code,
  output logic       disp_en,
  output logic [1:0] grant,
  output logic       busy
);

  localparam dwell_cnt_t DWELL_LOAD = dwell_cnt_t'(DWELL_CYCLES - 1);
  localparam blank_cnt_t BLANK_LOAD = (BLANK_CYCLES == 0) ? '0 : blank_cnt_t'(BLANK_CYCLES - 1);

  state_e     state_q;
  dwell_cnt_t cnt_q;
  logic [1:0] ack_q;
  logic [1:0] grant_q;
  logic [2:0] ascii_q;
  logic       disp_en_q;
  logic       busy_q;

  logic [1:0] arb_gnt;
  logic       accept_d;

  assign accept_d = (state_q == ST_IDLE) && (req != 2'b00);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .accept_i (accept_d),
    .grant_o  (arb_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ack_q     <= 2'b00;
      grant_q   <= 2'b00;
      ascii_q   <= 3'd0;
      disp_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            state_q   <= ST_SHOW;
            cnt_q     <= DWELL_LOAD;
            ack_q     <= arb_gnt;
            grant_q   <= arb_gnt;
            ascii_q   <= arb_gnt[1] ? code1 : code0;
            disp_en_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == '0) begin
            grant_q   <= 2'b00;
            disp_en_q <= 1'b0;
            // With no blanking gap the slot ends straight into IDLE
            if (BLANK_CYCLES == 0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_BLANK;
              cnt_q   <= dwell_cnt_t'(BLANK_LOAD);
            end
          end else begin
            cnt_q <= cnt_q - dwell_cnt_t'(1);
          end
        end
        ST_BLANK: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - dwell_cnt_t'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          grant_q   <= 2'b00;
          disp_en_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign ascii_code = ascii_q;
  assign disp_en    = disp_en_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dot_matrix_display_scheduler.sv
// Bench for dot_matrix_display_scheduler: slot-age reference model plus directed and random scenarios.
module tb_dot_matrix_display_scheduler;

  localparam int D = 4;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [2:0] code0 = 3'd0;
  logic [2:0] code1 = 3'd0;
  logic [1:0] ack;
  logic [2:0] ascii_code;
  logic       disp_en;
  logic [1:0] grant;
  logic       busy;

  logic [1:0] req2 = 2'b00;
  logic [2:0] c2_0 = 3'd0;
  logic [2:0] c2_1 = 3'd0;
  logic [1:0] ack2;
  logic [2:0] ascii2;
  logic       disp_en2;
  logic [1:0] grant2;
  logic       busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dot_matrix_display_scheduler #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) u_dut (
    .clk(clk), .rst(rst), .req(req), .code0(code0), .code1(code1),
    .ack(ack), .ascii_code(ascii_code), .disp_en(disp_en), .grant(grant), .busy(busy)
  );

  dot_matrix_display_scheduler #(.DWELL_CYCLES(D), .BLANK_CYCLES(0)) u_dut_b0 (
    .clk(clk), .rst(rst), .req(req2), .code0(c2_0), .code1(c2_1),
    .ack(ack2), .ascii_code(ascii2), .disp_en(disp_en2), .grant(grant2), .busy(busy2)
  );

  logic [8:0] dut_vec;
  assign dut_vec = {ack, grant, disp_en, busy, ascii_code};

  // Reference model: a slot is described only by its winner, latched code and age since acceptance
  bit         m_idle = 1'b1;
  int         m_age = 0;
  bit         m_win = 1'b0;
  bit         m_ptr = 1'b0;
  logic [2:0] m_code = 3'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle = 1'b1;
      m_age  = 0;
      m_code = 3'd0;
      m_ptr  = 1'b0;
    end else if (m_idle) begin
      if (req != 2'b00) begin
        m_win  = (req == 2'b11) ? m_ptr : req[1];
        m_code = m_win ? code1 : code0;
        m_ptr  = !m_win;
        m_idle = 1'b0;
        m_age  = 0;
      end
    end else begin
      m_age = m_age + 1;
      if (m_age >= D + B) m_idle = 1'b1;
    end
  end

  function automatic logic [8:0] exp_vec();
    logic [1:0] oh;
    logic       show;
    oh   = m_win ? 2'b10 : 2'b01;
    show = !m_idle && (m_age < D);
    return {(!m_idle && m_age == 0) ? oh : 2'b00, show ? oh : 2'b00, show, !m_idle, m_code};
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 9'd0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", dut_vec, 9'd0);
    end
    @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model got=%b exp=%b", dut_vec, exp_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int en_cnt = 0;
    int busy_cnt = 0;
    req = 2'b01; code0 = 3'd3;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL single_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (k == 1) begin
        checks++;
        if (ack !== 2'b01 || ascii_code !== 3'd3) begin
          errors++;
          $display("FAIL single_ack got ack=%b code=%0d exp ack=01 code=3", ack, ascii_code);
        end
        req = 2'b00;
      end
      if (k > 1) begin
        checks++;
        if (ack !== 2'b00) begin
          errors++;
          $display("FAIL single_ack_once k=%0d got=%b exp=00", k, ack);
        end
      end
      en_cnt += disp_en;
      busy_cnt += busy;
    end
    checks++;
    if (en_cnt != D || busy_cnt != D + B) begin
      errors++;
      $display("FAIL single_timing got en=%0d busy=%0d exp en=%0d busy=%0d", en_cnt, busy_cnt, D, D + B);
    end
  endtask

  task automatic test_contention();
    int         acc_t[$];
    logic [2:0] acc_c[$];
    logic [1:0] acc_a[$];
    logic [2:0] exp_c[4] = '{3'd1, 3'd5, 3'd1, 3'd5};
    logic [1:0] exp_a[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req = 2'b11; code0 = 3'd1; code1 = 3'd5;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL contention_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (ack != 2'b00) begin
        acc_t.push_back(k); acc_c.push_back(ascii_code); acc_a.push_back(ack);
      end
    end
    req = 2'b00;
    checks++;
    if (acc_t.size() != 4) begin
      errors++;
      $display("FAIL contention_slots got=%0d exp=4", acc_t.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_c[i] !== exp_c[i] || acc_a[i] !== exp_a[i]) begin
          errors++;
          $display("FAIL contention_slot%0d got code=%0d ack=%b exp code=%0d ack=%b", i, acc_c[i], acc_a[i], exp_c[i], exp_a[i]);
        end
        if (i > 0) begin
          checks++;
          if (acc_t[i] - acc_t[i-1] != D + B + 1) begin
            errors++;
            $display("FAIL contention_period got=%0d exp=%0d", acc_t[i] - acc_t[i-1], D + B + 1);
          end
        end
      end
    end
    for (int k = 0; k < 12 && busy; k++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_drain got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_withdraw();
    bit saw1 = 1'b0;
    req = 2'b01; code0 = 3'd2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL withdraw_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (ack[1] || grant[1]) saw1 = 1'b1;
      if (k == 1) req = 2'b00;
      if (k == 2) begin req = 2'b10; code1 = 3'd7; end
      if (k == 3) req = 2'b00;
    end
    checks++;
    if (saw1) begin
      errors++;
      $display("FAIL withdraw_no_slot got served=1 exp served=0");
    end
  endtask

  task automatic test_midreset();
    req = 2'b01; code0 = 3'd4;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (disp_en !== 1'b1 || ascii_code !== 3'd4) begin
      errors++;
      $display("FAIL midreset_show got en=%b code=%0d exp en=1 code=4", disp_en, ascii_code);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({disp_en, grant, ascii_code, ack, busy} !== 9'd0) begin
      errors++;
      $display("FAIL midreset_abort got=%b exp=%b", {disp_en, grant, ascii_code, ack, busy}, 9'd0);
    end
    @(negedge clk);
    rst = 1'b0; req = 2'b10; code1 = 3'd2;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || ack !== 2'b10 || ascii_code !== 3'd2) begin
      errors++;
      $display("FAIL midreset_regrant got grant=%b ack=%b code=%0d exp 10 10 2", grant, ack, ascii_code);
    end
    req = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL midreset_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_code_change();
    req = 2'b01; code0 = 3'd3;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 6) begin
        checks++;
        if (ascii_code !== 3'd3) begin
          errors++;
          $display("FAIL codechg_hold k=%0d got=%0d exp=3", k, ascii_code);
        end
      end
      if (k == 8) begin
        checks++;
        if (ascii_code !== 3'd6 || ack !== 2'b01) begin
          errors++;
          $display("FAIL codechg_next got code=%0d ack=%b exp code=6 ack=01", ascii_code, ack);
        end
      end
      if (k == 1) begin req = 2'b00; code0 = 3'd6; end
      if (k == 7) req = 2'b01;
      if (k == 8) req = 2'b00;
    end
    for (int k = 0; k < 8; k++) @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      req   = 2'($urandom_range(0, 3));
      code0 = 3'($urandom);
      code1 = 3'($urandom);
    end
    req = 2'b00;
  endtask

  task automatic test_blank0();
    int wait_n = 0;
    req2 = 2'b01; c2_0 = 3'd5;
    @(negedge clk);
    while (!disp_en2 && wait_n < 6) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (disp_en2 !== 1'b1) begin
      errors++;
      $display("FAIL blank0_start got en=%b exp=1", disp_en2);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (disp_en2 !== ((i % 5) != 4) || ack2 !== (((i % 5) == 0) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL blank0_pattern i=%0d got en=%b ack=%b", i, disp_en2, ack2);
      end
      @(negedge clk);
    end
    checks++;
    if (ascii2 !== 3'd5) begin
      errors++;
      $display("FAIL blank0_code got=%0d exp=5", ascii2);
    end
    req2 = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_withdraw();
    test_midreset();
    test_code_change();
    test_random();
    test_blank0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_matrix_display_scheduler.md
DOT_MATRIX_DISPLAY_SCHEDULER -- requirements
Module: dot_matrix_display_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000, cycles one character is shown (legal range 1..65535).
REQ-002 SHALL have parameter BLANK_CYCLES, default 8, display-off gap after each character (legal range 0..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  2  per-requester display request; bit0 = requester 0, bit1 = requester 1.
REQ-006 SHALL have port code0  input  3  digit code of requester 0, valid while req[0]=1.
REQ-007 SHALL have port code1  input  3  digit code of requester 1, valid while req[1]=1.
REQ-008 SHALL have port ack  output  2  one-cycle acceptance pulse per requester.
REQ-009 SHALL have port ascii_code  output  3  digit code driven to the dot-matrix controller.
REQ-010 SHALL have port disp_en  output  1  1 = character displayed, 0 = display blanked.
REQ-011 SHALL have port grant  output  2  one-hot owner of the current display slot, 2'b00 when none.
REQ-012 SHALL have port busy  output  1  1 whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHOW, BLANK; all outputs registered.
REQ-014 In IDLE with req=2'b00, SHALL remain in IDLE with disp_en=0, grant=2'b00, ack=2'b00.
REQ-015 In IDLE with any req bit set at a rising edge, SHALL at that edge select one winner, latch its code into ascii_code, pulse ack[winner] for exactly one cycle, set grant to winner, set disp_en=1, go to SHOW.
REQ-016 SHALL arbitrate round-robin: with both req bits set, the requester not served last wins; pointer after reset favours requester 0.
REQ-017 With a single req bit set, SHALL grant that requester regardless of the round-robin pointer.
REQ-018 SHALL hold disp_en=1 and ascii_code constant for exactly DWELL_CYCLES cycles in SHOW, using a 16-bit down-counter.
REQ-019 SHALL ignore req and code changes during SHOW and BLANK; no ack pulse in those states.
REQ-020 On SHOW expiry, SHALL enter BLANK for exactly BLANK_CYCLES cycles with disp_en=0, grant=2'b00, ascii_code retained; if BLANK_CYCLES=0, SHALL go directly to IDLE.
REQ-021 SHALL spend at least one cycle in IDLE between slots, giving a back-to-back period of DWELL_CYCLES+BLANK_CYCLES+1 cycles.
REQ-022 A requester SHALL hold req and code stable until its ack; dropping req before ack withdraws the request without penalty.
REQ-023 A req still high in the cycle after ack SHALL be treated as a new request for the next slot.

Reset
REQ-024 On rst=1, SHALL immediately force state=IDLE, ack=2'b00, grant=2'b00, disp_en=0, busy=0, ascii_code=3'd0, counter=0, round-robin pointer to favour requester 0.
REQ-025 Reset asserted mid-SHOW or mid-BLANK SHALL abort the slot with no further ack; after rst deasserts, the first rising edge SHALL evaluate req as in IDLE.

Structure
REQ-026 SHALL place the FSM state encoding and the counter widths (16-bit dwell, 8-bit blank) in shared package dot_matrix_pkg.
REQ-027 SHALL implement arbitration in sub-module rr_arbiter2 (2-bit request, one-hot grant, pointer update on accept).

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-028 Single request: req=01, code0=3 -> ack=01 one cycle; disp_en=1 with ascii_code=3 for 4 cycles; disp_en=0 for 2 cycles; busy low after 6 cycles.
REQ-029 Contention: req=11 held, code0=1, code1=5 -> slots show 1, 5, 1, 5 with ack alternating 01, 10, and a 7-cycle period.
REQ-030 Withdrawal: req[1] pulsed during SHOW of requester 0 and dropped before IDLE -> no ack[1] and no slot for requester 1.
REQ-031 Mid-slot reset: rst asserted on SHOW cycle 2 -> disp_en=0, grant=00, ascii_code=0 immediately; with req=10 after deassert, first grant goes to requester 1.
REQ-032 BLANK_CYCLES=0 build: req=01 held -> disp_en high 4 cycles, low 1 cycle (IDLE), repeating.
REQ-033 Code change during SHOW: code0 changed 3 -> 6 mid-slot -> ascii_code stays 3 until the next accepted slot.
